// File: rtl/rx_cmd_ctrl.sv
// rx_cmd_ctrl: decodes UART command frames into register-file and ALU strobes, aborting stalled commands.
module rx_cmd_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VALID,
  input  logic                  ALU_OUT_VALID,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  WrEn,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic                  RdEn,
  output logic                  ALU_EN,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  CLK_GATE_EN,
  output logic                  CMD_ERR
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_CYCLES);
  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'('hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'('hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'('hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'('hDD);
  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_OPA, S_OPB, S_ALU_FUN, S_ALU_WAIT
  } state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic timed, expire;
  assign timed  = state != S_IDLE && state != S_ALU_WAIT;
  // a byte landing on the expiry cycle takes priority over the abort
  assign expire = timed && !RX_D_VALID && cnt == T_MAX;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      Address     <= '0;
      WrEn        <= 1'b0;
      WrData      <= '0;
      RdEn        <= 1'b0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      CMD_ERR     <= 1'b0;
    end else begin
      WrEn    <= 1'b0;
      RdEn    <= 1'b0;
      ALU_EN  <= 1'b0;
      CMD_ERR <= 1'b0;
      cnt     <= (!timed || RX_D_VALID || expire) ? '0 : cnt + CW'(cnt != T_MAX);
      if (expire) begin
        state       <= S_IDLE;
        CMD_ERR     <= 1'b1;
        CLK_GATE_EN <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (RX_D_VALID) begin
            if (RX_P_DATA == CMD_WR) state <= S_WR_ADDR;
            else if (RX_P_DATA == CMD_RD) state <= S_RD_ADDR;
            else if (RX_P_DATA == CMD_ALU) state <= S_OPA;
            else if (RX_P_DATA == CMD_FUN) begin
              state       <= S_ALU_FUN;
              CLK_GATE_EN <= 1'b1;
            end
          end
          S_WR_ADDR: if (RX_D_VALID) begin
            addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
            state  <= S_WR_DATA;
          end
          S_WR_DATA: if (RX_D_VALID) begin
            Address <= addr_q;
            WrData  <= RX_P_DATA;
            WrEn    <= 1'b1;
            state   <= S_IDLE;
          end
          S_RD_ADDR: if (RX_D_VALID) begin
            Address <= RX_P_DATA[ADDR_WIDTH-1:0];
            RdEn    <= 1'b1;
            state   <= S_IDLE;
          end
          S_OPA: if (RX_D_VALID) begin
            Address <= '0;
            WrData  <= RX_P_DATA;
            WrEn    <= 1'b1;
            state   <= S_OPB;
          end
          S_OPB: if (RX_D_VALID) begin
            Address     <= ADDR_WIDTH'(1);
            WrData      <= RX_P_DATA;
            WrEn        <= 1'b1;
            CLK_GATE_EN <= 1'b1;
            state       <= S_ALU_FUN;
          end
          S_ALU_FUN: if (RX_D_VALID) begin
            ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
            ALU_EN  <= 1'b1;
            state   <= S_ALU_WAIT;
          end
          S_ALU_WAIT: if (ALU_OUT_VALID) begin
            CLK_GATE_EN <= 1'b0;
            state       <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// tb_rx_cmd_ctrl: table-driven per-cycle vectors plus directed timeout and reset sequences.
module tb_rx_cmd_ctrl;
  localparam int T = 10;
  logic CLK = 1'b0, RST = 1'b1;
  logic [7:0] RX_P_DATA = '0;
  logic RX_D_VALID = 1'b0, ALU_OUT_VALID = 1'b0;
  logic [3:0] Address, ALU_FUN;
  logic [7:0] WrData;
  logic WrEn, RdEn, ALU_EN, CLK_GATE_EN, CMD_ERR;
  logic [20:0] outs;
  int n_cmp = 0, n_bad = 0;
  rx_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VALID(RX_D_VALID),
    .ALU_OUT_VALID(ALU_OUT_VALID), .Address(Address), .WrEn(WrEn), .WrData(WrData),
    .RdEn(RdEn), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN), .CMD_ERR(CMD_ERR)
  );
  always #5 CLK = ~CLK;
  assign outs = {WrEn, RdEn, ALU_EN, CLK_GATE_EN, CMD_ERR, Address, WrData, ALU_FUN};
  typedef struct {
    logic v;
    logic [7:0] d;
    logic av;
    logic [20:0] exp;
  } vec_t;
  vec_t tv[24];
  function automatic logic [20:0] o(input logic wr, rd, aen, g, e, input logic [3:0] a, input logic [7:0] w, input logic [3:0] f);
    return {wr, rd, aen, g, e, a, w, f};
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VALID = 1'b1;
    @(negedge CLK);
    RX_D_VALID = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int err_at;
    logic wr_seen;
    tv = '{
      '{1'b1, 8'hAA, 1'b0, o(0,0,0,0,0, 4'h0, 8'h00, 4'h0)},
      '{1'b1, 8'h05, 1'b0, o(0,0,0,0,0, 4'h0, 8'h00, 4'h0)},
      '{1'b1, 8'h3C, 1'b0, o(1,0,0,0,0, 4'h5, 8'h3C, 4'h0)},
      '{1'b0, 8'h00, 1'b0, o(0,0,0,0,0, 4'h5, 8'h3C, 4'h0)},
      '{1'b1, 8'hBB, 1'b0, o(0,0,0,0,0, 4'h5, 8'h3C, 4'h0)},
      '{1'b1, 8'h0A, 1'b0, o(0,1,0,0,0, 4'hA, 8'h3C, 4'h0)},
      '{1'b0, 8'h00, 1'b0, o(0,0,0,0,0, 4'hA, 8'h3C, 4'h0)},
      '{1'b1, 8'h55, 1'b0, o(0,0,0,0,0, 4'hA, 8'h3C, 4'h0)},
      '{1'b1, 8'hCC, 1'b0, o(0,0,0,0,0, 4'hA, 8'h3C, 4'h0)},
      '{1'b1, 8'h12, 1'b0, o(1,0,0,0,0, 4'h0, 8'h12, 4'h0)},
      '{1'b1, 8'h34, 1'b0, o(1,0,0,1,0, 4'h1, 8'h34, 4'h0)},
      '{1'b1, 8'h01, 1'b0, o(0,0,1,1,0, 4'h1, 8'h34, 4'h1)},
      '{1'b1, 8'hAA, 1'b0, o(0,0,0,1,0, 4'h1, 8'h34, 4'h1)},
      '{1'b0, 8'h00, 1'b0, o(0,0,0,1,0, 4'h1, 8'h34, 4'h1)},
      '{1'b0, 8'h00, 1'b1, o(0,0,0,0,0, 4'h1, 8'h34, 4'h1)},
      '{1'b1, 8'hDD, 1'b0, o(0,0,0,1,0, 4'h1, 8'h34, 4'h1)},
      '{1'b1, 8'hF3, 1'b0, o(0,0,1,1,0, 4'h1, 8'h34, 4'h3)},
      '{1'b1, 8'hAA, 1'b1, o(0,0,0,0,0, 4'h1, 8'h34, 4'h3)},
      '{1'b1, 8'hBB, 1'b0, o(0,0,0,0,0, 4'h1, 8'h34, 4'h3)},
      '{1'b1, 8'hE7, 1'b0, o(0,1,0,0,0, 4'h7, 8'h34, 4'h3)},
      '{1'b1, 8'hAA, 1'b0, o(0,0,0,0,0, 4'h7, 8'h34, 4'h3)},
      '{1'b1, 8'hAA, 1'b0, o(0,0,0,0,0, 4'h7, 8'h34, 4'h3)},
      '{1'b1, 8'hCC, 1'b0, o(1,0,0,0,0, 4'hA, 8'hCC, 4'h3)},
      '{1'b0, 8'h00, 1'b0, o(0,0,0,0,0, 4'hA, 8'hCC, 4'h3)}
    };
    repeat (2) @(negedge CLK);
    chk("reset_outputs", 32'(outs), 32'(0));
    RST = 1'b0;
    for (int i = 0; i < 24; i++) begin
      RX_P_DATA = tv[i].d;
      RX_D_VALID = tv[i].v;
      ALU_OUT_VALID = tv[i].av;
      @(negedge CLK);
      chk($sformatf("vec%0d", i), 32'(outs), 32'(tv[i].exp));
    end
    RX_D_VALID = 1'b0;
    ALU_OUT_VALID = 1'b0;
    // write command stalled after the address: error must land T+1 cycles later
    send(8'hAA);
    send(8'h02);
    err_at = 0;
    wr_seen = 1'b0;
    for (int i = 1; i <= 3 * T; i++) begin
      @(negedge CLK);
      wr_seen |= WrEn;
      if (CMD_ERR && err_at == 0) err_at = i;
    end
    chk("timeout_err_cycle", 32'(err_at), 32'(T + 1));
    chk("timeout_no_wr", 32'(wr_seen), 32'(0));
    send(8'hBB);
    send(8'h02);
    chk("read_after_timeout", 32'({RdEn, WrEn, CMD_ERR, Address}), 32'({1'b1, 1'b0, 1'b0, 4'h2}));
    // byte exactly on the expiry cycle completes the write
    send(8'hAA);
    send(8'h02);
    repeat (T) @(negedge CLK);
    chk("pre_expiry_no_err", 32'(CMD_ERR), 32'(0));
    send(8'h77);
    chk("expiry_byte_wins", 32'({WrEn, CMD_ERR, Address, WrData}), 32'({1'b1, 1'b0, 4'h2, 8'h77}));
    @(negedge CLK);
    chk("expiry_no_late_err", 32'({WrEn, CMD_ERR}), 32'(0));
    // stalled 0xDD command drops the clock gate on abort
    send(8'hDD);
    chk("dd_gate_on", 32'(CLK_GATE_EN), 32'(1));
    repeat (T) @(negedge CLK);
    chk("dd_before_expiry", 32'({CMD_ERR, CLK_GATE_EN}), 32'({1'b0, 1'b1}));
    @(negedge CLK);
    chk("dd_timeout", 32'({CMD_ERR, CLK_GATE_EN, ALU_EN}), 32'({1'b1, 1'b0, 1'b0}));
    // asynchronous reset in the middle of an ALU command
    send(8'hCC);
    send(8'h12);
    send(8'h34);
    chk("cc_gate_on", 32'(CLK_GATE_EN), 32'(1));
    #2 RST = 1'b1;
    #1 chk("async_reset", 32'(outs), 32'(0));
    @(negedge CLK);
    RST = 1'b0;
    send(8'hAA);
    send(8'h09);
    send(8'h5A);
    chk("write_after_reset", 32'({WrEn, CLK_GATE_EN, Address, WrData}), 32'({1'b1, 1'b0, 4'h9, 8'h5A}));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
